// File: rtl/debounce_pkg.sv
// Shared types and defaults for the 8-channel switch debouncer.
//   ch_state_e     : per-channel qualification state
//   CLK_DIV_DEF    : default clk cycles per sample tick
//   STABLE_CNT_DEF : default number of differing ticks needed to accept a new level
package debounce_pkg;

  typedef enum logic {
    ST_STABLE,
    ST_CHANGING
  } ch_state_e;

  localparam int unsigned CLK_DIV_DEF    = 50000;
  localparam int unsigned STABLE_CNT_DEF = 4;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: two-flop synchroniser, tick-driven qualification counter,
// registered debounced level and one-cycle edge pulses.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   sw_i   : raw asynchronous switch level
//   tick_i : sample strobe from the shared prescaler
//   x_o    : debounced level (registered)
//   rise_o : one-cycle pulse when x_o goes 0->1
//   fall_o : one-cycle pulse when x_o goes 1->0
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  input  logic tick_i,
  output logic x_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CNT - 1);

  logic            meta_q, s_q;
  ch_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            x_q, x_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            qual_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      s_q    <= 1'b0;
    end else begin
      meta_q <= sw_i;
      s_q    <= meta_q;
    end
  end

  // A single-tick qualifier accepts straight from ST_STABLE; otherwise the last
  // count is only reachable while ST_CHANGING.
  assign qual_done = (cnt_q == CntMax) && ((state_q == ST_CHANGING) || (STABLE_CNT == 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_i) begin
      if (s_q == x_q) begin
        // Input agrees with the output: any partial qualification is a bounce.
        cnt_d   = '0;
        state_d = ST_STABLE;
      end else if (qual_done) begin
        x_d     = s_q;
        cnt_d   = '0;
        state_d = ST_STABLE;
        rise_d  = s_q;
        fall_d  = ~s_q;
      end else begin
        cnt_d   = cnt_q + CntW'(1);
        state_d = ST_CHANGING;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign x_o    = x_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/debounce8.sv
// 8-channel switch/key debouncer with a shared sample prescaler.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   sw      : raw bouncing switch levels
//   x       : debounced levels (feeds the 8-to-3 priority encoder request input)
//   rise    : per-bit one-cycle 0->1 pulses on x
//   fall    : per-bit one-cycle 1->0 pulses on x
//   changed : one-cycle pulse when any bit of x changed
module debounce8
  import debounce_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  output logic [7:0] x,
  output logic [7:0] rise,
  output logic [7:0] fall,
  output logic       changed
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            tick;

  // With CLK_DIV == 1 div_q stays at 0 == DivMax, so tick is high every cycle.
  assign tick  = (div_q == DivMax);
  assign div_d = tick ? '0 : div_q + DivW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT(STABLE_CNT)
    ) u_ch (
      .clk_i (clk),
      .rst_ni(rst_n),
      .sw_i  (sw[i]),
      .tick_i(tick),
      .x_o   (x[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i])
    );
  end

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_debounce8.sv
// Directed bench for debounce8 with CLK_DIV=4, STABLE_CNT=3.
// ecount counts rising edges since the last reset release; ticks are consumed
// at edges where ecount is a multiple of 4, and a sw change applied just after
// edge e reaches the channel's synchronised input after edge e+2.
module tb_debounce8;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic [7:0] x;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       changed;

  int n_checks = 0;
  int n_pass   = 0;
  int ecount   = 0;
  int pulses;

  debounce8 #(
    .CLK_DIV   (4),
    .STABLE_CNT(3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw     (sw),
    .x      (x),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (ecount %0d)", tag, got, exp, ecount);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      ecount++;
    end
    #1;
  endtask

  task automatic go_to(input int target);
    go(target - ecount);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    ecount = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = 8'hFF;

    // Reset with all switches high
    go(3);
    check("rst_x", x, 8'h00);
    check("rst_rise", rise, 8'h00);
    check("rst_fall", fall, 8'h00);
    check("rst_changed", {7'b0, changed}, 8'h00);
    release_reset();
    go_to(11);
    check("pwr_x_pre", x, 8'h00);
    go_to(12);
    check("pwr_x", x, 8'hFF);
    check("pwr_rise", rise, 8'hFF);
    check("pwr_changed", {7'b0, changed}, 8'h01);
    go_to(13);
    check("pwr_rise_end", rise, 8'h00);
    check("pwr_changed_end", {7'b0, changed}, 8'h00);

    // Drop everything to get a clean all-zero baseline
    sw = 8'h00;
    go_to(23);
    check("drop_x_pre", x, 8'hFF);
    go_to(24);
    check("drop_x", x, 8'h00);
    check("drop_fall", fall, 8'hFF);
    check("drop_rise", rise, 8'h00);

    // Clean press on sw[3]
    go_to(25);
    sw = 8'h08;
    go_to(35);
    check("press_x_pre", x, 8'h00);
    go_to(36);
    check("press_x", x, 8'h08);
    check("press_rise", rise, 8'h08);
    check("press_fall", fall, 8'h00);
    go_to(37);
    check("press_rise_end", rise, 8'h00);

    // Bounce on sw[5]: high 2 ticks, low 1 tick, high 3 ticks
    sw = 8'h28;
    pulses = 0;
    go_to(44);
    if (rise[5]) pulses++;
    sw = 8'h08;
    check("bounce_x_burst", x, 8'h08);
    while (ecount < 48) begin
      go(1);
      if (rise[5]) pulses++;
    end
    sw = 8'h28;
    while (ecount < 59) begin
      go(1);
      if (rise[5]) pulses++;
    end
    check("bounce_x_pre", x, 8'h08);
    go(1);
    if (rise[5]) pulses++;
    check("bounce_x", x, 8'h28);
    check("bounce_rise", rise, 8'h20);
    while (ecount < 66) begin
      go(1);
      if (rise[5]) pulses++;
    end
    check("bounce_pulses", 8'(pulses), 8'd1);

    // Simultaneous rise on channels 0 and 7 (sw[3], sw[5] stay high)
    go_to(69);
    sw = 8'hA9;
    go_to(79);
    check("simul_x_pre", x, 8'h28);
    go_to(80);
    check("simul_x", x, 8'hA9);
    check("simul_rise", rise, 8'h81);
    check("simul_changed", {7'b0, changed}, 8'h01);
    go_to(81);
    check("simul_rise_end", rise, 8'h00);
    check("simul_changed_end", {7'b0, changed}, 8'h00);

    // Release sw[3]
    sw = 8'hA1;
    go_to(91);
    check("rel_x_pre", x, 8'hA9);
    go_to(92);
    check("rel_x", x, 8'hA1);
    check("rel_fall", fall, 8'h08);
    check("rel_rise", rise, 8'h00);
    go_to(93);
    check("rel_fall_end", fall, 8'h00);

    // Asynchronous reset between clock edges clears x at once
    rst_n = 1'b0;
    sw    = 8'h00;
    #1;
    check("async_x", x, 8'h00);
    go(2);
    release_reset();

    // Reset in the middle of channel 0 qualification
    go_to(1);
    sw = 8'h01;
    go_to(9);
    check("mid_cnt_before", 8'(dut.g_ch[0].u_ch.cnt_q), 8'd2);
    rst_n = 1'b0;
    #1;
    check("mid_cnt_reset", 8'(dut.g_ch[0].u_ch.cnt_q), 8'd0);
    check("mid_x_reset", x, 8'h00);
    go(2);
    release_reset();
    go_to(11);
    check("mid_x_pre", x, 8'h00);
    go_to(12);
    check("mid_x", x, 8'h01);
    check("mid_rise", rise, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
